// File: rtl/fetch_pkg.sv
// Shared types and constants for the KGP-RISC instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } fetch_state_e;

  localparam int unsigned DEF_RESET_VECTOR = 0;

  localparam logic [2:0] OPC_BRANCH = 3'b011;
  localparam logic [2:0] OPC_JUMP   = 3'b100;
  localparam logic [3:0] FC_CALL    = 4'd9;
  localparam logic [3:0] FC_RET     = 4'd10;

  // Returns {is_call, is_ret} for the redirecting instruction's opcode/fcode.
  function automatic logic [1:0] ras_op(input logic [2:0] opcode, input logic [3:0] fcode);
    logic br;
    br = (opcode == OPC_BRANCH) || (opcode == OPC_JUMP);
    return {br && (fcode == FC_CALL), br && (fcode == FC_RET)};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Redirect and instruction-memory bus between the fetch unit and its surroundings.
interface fetch_unit_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 32
);
  logic               PC_select;
  logic [PC_W-1:0]    branch_PC;
  logic               is_call;
  logic               is_ret;
  logic               imem_rd_en;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;

  // Redirect inputs are a level request: the fetch unit acts on them only in a
  // non-stalled RUN cycle, so upstream holds them across a stall. imem_rdata
  // corresponds to the imem_addr launched at the previous edge whenever
  // imem_rd_en is high.
  modport master (
    input  PC_select, branch_PC, is_call, is_ret, imem_rdata,
    output imem_rd_en, imem_addr
  );

  modport slave (
    output PC_select, branch_PC, is_call, is_ret, imem_rdata,
    input  imem_rd_en, imem_addr
  );
endinterface

// File: rtl/fetch_unit_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop of an empty stack or a push/pop conflict sets a sticky error.
module ret_addr_stack #(
  parameter int RAS_DEPTH = 4,
  parameter int PC_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         conflict,
  input  logic [PC_W-1:0]              push_data,
  output logic [PC_W-1:0]              top,
  output logic [$clog2(RAS_DEPTH):0]   count,
  output logic                         err
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(RAS_DEPTH);

  logic [PC_W-1:0]  entries_q [RAS_DEPTH];
  logic [PC_W-1:0]  entries_d [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, wr_idx;
  logic [PTR_W:0]   count_q, count_d;
  logic             err_q, err_d;

  assign wr_idx = ptr_q + 1'b1;

  always_comb begin
    entries_d = entries_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    err_d     = err_q;
    if (conflict) begin
      err_d = 1'b1;
    end else if (push) begin
      entries_d[wr_idx] = push_data;
      ptr_d             = wr_idx;
      if (count_q != FULL) count_d = count_q + 1'b1;
    end else if (pop) begin
      if (count_q == '0) begin
        err_d = 1'b1;
      end else begin
        ptr_d   = ptr_q - 1'b1;
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) entries_q[i] <= '0;
      ptr_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      entries_q <= entries_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  assign top   = (count_q == '0) ? '0 : entries_q[ptr_q];
  assign count = count_q;
  assign err   = err_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: owns the PC, drives the instruction memory,
// squashes the wrong-path word after a redirect and predicts returns via the RAS.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W         = 8,
  parameter int              INSTR_W      = 32,
  parameter int              RAS_DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(DEF_RESET_VECTOR)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall,
  fetch_unit_if.master               bus,
  output logic [INSTR_W-1:0]         instr,
  output logic [PC_W-1:0]            instr_pc,
  output logic                       instr_valid,
  output logic [PC_W-1:0]            ret_addr,
  output logic                       ras_err,
  output fetch_state_e               state_dbg,
  output logic [$clog2(RAS_DEPTH):0] ras_count_dbg
);
  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    addr_q, addr_d;
  logic [PC_W-1:0]    ipc_q, ipc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               take, push, pop, conflict;
  logic [PC_W-1:0]    target;

  // Only an instruction issued in RUN is on the correct path, so only RUN redirects.
  assign take     = (state_q == RUN) && bus.PC_select && !stall;
  assign conflict = take && bus.is_call && bus.is_ret;
  assign push     = take && bus.is_call && !bus.is_ret;
  assign pop      = take && bus.is_ret && !bus.is_call;
  assign target   = pop ? ret_addr : bus.branch_PC;

  ret_addr_stack #(.RAS_DEPTH(RAS_DEPTH), .PC_W(PC_W)) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .conflict  (conflict),
    .push_data (instr_pc + 1'b1),
    .top       (ret_addr),
    .count     (ras_count_dbg),
    .err       (ras_err)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ipc_d   = ipc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (!stall) begin
      instr_d = bus.imem_rdata;
      ipc_d   = addr_q;
      valid_d = 1'b1;
      addr_d  = addr_q + 1'b1;
      unique case (state_q)
        FILL, BUBBLE: state_d = RUN;
        RUN: begin
          state_d = RUN;
          if (take) begin
            // The word returning now follows the redirecting instruction: squash it.
            state_d = BUBBLE;
            valid_d = 1'b0;
            addr_d  = target;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      addr_q  <= RESET_VECTOR;
      ipc_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ipc_q   <= ipc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign bus.imem_rd_en = rst_n && !stall;
  assign bus.imem_addr  = addr_q;
  assign instr          = instr_q;
  assign instr_pc       = ipc_q;
  assign instr_valid    = valid_q;
  assign state_dbg      = state_q;
endmodule
